// File: rtl/next_field_iter_if.sv
// Bundle between the NFI controller (master) and the generation engine (slave):
// generation start handshake, status, cell write port and display row read port.
interface next_field_iter_if #(
  parameter int FIELD_W  = 16,
  parameter int FIELD_H  = 16,
  parameter int GEN_BITS = 16
);
  localparam int XW = $clog2(FIELD_W);
  localparam int YW = $clog2(FIELD_H);

  // Handshake: i_go is the request and o_NFI_allowed the ready; a generation
  // starts only on a posedge where both are high. i_go while not ready is dropped.
  logic                i_go;
  logic                o_NFI_allowed;
  logic                o_done;
  logic [GEN_BITS-1:0] o_gen_cnt;
  logic                i_wr_en;
  logic [XW-1:0]       i_wr_x;
  logic [YW-1:0]       i_wr_y;
  logic                i_wr_val;
  logic [YW-1:0]       i_rd_row;
  logic [FIELD_W-1:0]  o_rd_data;

  modport master (
    output i_go, i_wr_en, i_wr_x, i_wr_y, i_wr_val, i_rd_row,
    input  o_NFI_allowed, o_done, o_gen_cnt, o_rd_data
  );

  modport slave (
    input  i_go, i_wr_en, i_wr_x, i_wr_y, i_wr_val, i_rd_row,
    output o_NFI_allowed, o_done, o_gen_cnt, o_rd_data
  );
endinterface

// File: rtl/next_field_iter.sv
// Game-of-Life (B3/S23) generation engine on a toroidal field: one row per cycle
// into a shadow buffer, then a single-cycle commit to the displayed field.
module next_field_iter #(
  parameter int FIELD_W  = 16,
  parameter int FIELD_H  = 16,
  parameter int GEN_BITS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  next_field_iter_if.slave bus,
  output logic [1:0]       dbg_state
);
  localparam int YW = $clog2(FIELD_H);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, COMMIT = 2'd2} state_t;

  state_t              state, state_nxt;
  logic [YW-1:0]       row, row_nxt;
  logic [FIELD_W-1:0]  cur [FIELD_H];
  logic [FIELD_W-1:0]  nxt [FIELD_H];
  logic [FIELD_W-1:0]  up_row, mid_row, dn_row, life_row;
  logic [YW-1:0]       row_up, row_dn;
  logic                last_row, wr_ok, rd_ok;
  logic                done_q;
  logic [GEN_BITS-1:0] gen_q;
  logic [FIELD_W-1:0]  rd_q;
  int                  xl, xr;
  logic [3:0]          n;

  assign bus.o_NFI_allowed = (state == IDLE);
  assign bus.o_done        = done_q;
  assign bus.o_gen_cnt     = gen_q;
  assign bus.o_rd_data     = rd_q;
  assign dbg_state         = state;

  assign last_row = (row == YW'(FIELD_H - 1));
  assign wr_ok    = bus.i_wr_en && (state == IDLE) &&
                    (32'(bus.i_wr_x) < FIELD_W) && (32'(bus.i_wr_y) < FIELD_H);
  assign rd_ok    = (32'(bus.i_rd_row) < FIELD_H);

  always_comb begin
    state_nxt = state;
    row_nxt   = row;
    case (state)
      IDLE: if (bus.i_go) begin
        state_nxt = CALC;
        row_nxt   = '0;
      end
      CALC: begin
        row_nxt = row + YW'(1);
        if (last_row) begin
          state_nxt = COMMIT;
          row_nxt   = '0;
        end
      end
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      row   <= '0;
    end else begin
      state <= state_nxt;
      row   <= row_nxt;
    end
  end

  // Neighbour rows wrap top/bottom; the column wrap is handled per cell below.
  assign row_up  = (row == '0) ? YW'(FIELD_H - 1) : row - YW'(1);
  assign row_dn  = last_row ? '0 : row + YW'(1);
  assign up_row  = cur[row_up];
  assign mid_row = cur[row];
  assign dn_row  = cur[row_dn];

  always_comb begin
    life_row = '0;
    xl       = 0;
    xr       = 0;
    n        = '0;
    for (int x = 0; x < FIELD_W; x++) begin
      xl = (x == 0) ? FIELD_W - 1 : x - 1;
      xr = (x == FIELD_W - 1) ? 0 : x + 1;
      n  = 4'(up_row[xl]) + 4'(up_row[x]) + 4'(up_row[xr]) +
           4'(mid_row[xl]) + 4'(mid_row[xr]) +
           4'(dn_row[xl]) + 4'(dn_row[x]) + 4'(dn_row[xr]);
      life_row[x] = (n == 4'd3) || (mid_row[x] && (n == 4'd2));
    end
  end

  // Edits only reach cur in IDLE, so a write and i_go on the same edge
  // land before the first CALC row samples the field.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int y = 0; y < FIELD_H; y++) begin
        cur[y] <= '0;
        nxt[y] <= '0;
      end
      done_q <= 1'b0;
      gen_q  <= '0;
      rd_q   <= '0;
    end else begin
      done_q <= (state == COMMIT);
      if (state == COMMIT) begin
        for (int y = 0; y < FIELD_H; y++) cur[y] <= nxt[y];
        gen_q <= gen_q + GEN_BITS'(1);
      end else if (wr_ok) begin
        cur[bus.i_wr_y][bus.i_wr_x] <= bus.i_wr_val;
      end
      if (state == CALC) nxt[row] <= life_row;
      rd_q <= rd_ok ? cur[bus.i_rd_row] : '0;
    end
  end
endmodule

// File: tb/tb_next_field_iter.sv
// Directed bench for next_field_iter: pattern table with hand-computed results,
// plus timing, reset, edit-port and randomised reference-model sequences.
module tb_next_field_iter;
  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         n_vec = 0;
  int         n_err = 0;

  next_field_iter_if #(.FIELD_W(16), .FIELD_H(16), .GEN_BITS(16)) bus ();

  next_field_iter #(.FIELD_W(16), .FIELD_H(16), .GEN_BITS(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  typedef struct {
    string       name;
    int          gens;
    logic [15:0] init [16];
    logic [15:0] exp  [16];
  } vec_t;

  vec_t        vecs [7];
  logic [15:0] m_cur [16];
  logic [15:0] exp_f [16];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.i_go = 1'b0;
    bus.i_wr_en = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic load_field(input logic [15:0] f [16]);
    for (int y = 0; y < 16; y++) begin
      for (int x = 0; x < 16; x++) begin
        bus.i_wr_en  = 1'b1;
        bus.i_wr_x   = 4'(x);
        bus.i_wr_y   = 4'(y);
        bus.i_wr_val = f[y][x];
        step();
      end
    end
    bus.i_wr_en = 1'b0;
  endtask

  task automatic wait_done(string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      seen = bus.o_done;
    end
    check({tag, "_done_timeout"}, 32'(seen), 32'd1);
  endtask

  task automatic run_gen(string tag);
    bus.i_go = 1'b1;
    step();
    bus.i_go = 1'b0;
    wait_done(tag);
  endtask

  task automatic check_field(string tag, input logic [15:0] f [16]);
    for (int y = 0; y < 16; y++) begin
      bus.i_rd_row = 4'(y);
      step();
      check($sformatf("%s_row%0d", tag, y), 32'(bus.o_rd_data), 32'(f[y]));
    end
  endtask

  // Reference generation: explicit 3x3 neighbourhood walk with modular indices.
  task automatic model_life();
    logic [15:0] t [16];
    int cnt;
    for (int y = 0; y < 16; y++) begin
      for (int x = 0; x < 16; x++) begin
        cnt = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            if (dy != 0 || dx != 0)
              cnt += int'(m_cur[(y + dy + 16) % 16][(x + dx + 16) % 16]);
        t[y][x] = (cnt == 3) || (m_cur[y][x] && cnt == 2);
      end
    end
    m_cur = t;
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.i_go     = 1'b0;
    bus.i_wr_en  = 1'b0;
    bus.i_wr_x   = '0;
    bus.i_wr_y   = '0;
    bus.i_wr_val = 1'b0;
    bus.i_rd_row = '0;

    foreach (vecs[i]) begin
      vecs[i].init = '{default: 16'h0000};
      vecs[i].exp  = '{default: 16'h0000};
    end
    vecs[0].name = "blinker1";  vecs[0].gens = 1;
    vecs[0].init[5] = 16'h0070;
    vecs[0].exp[4] = 16'h0020; vecs[0].exp[5] = 16'h0020; vecs[0].exp[6] = 16'h0020;
    vecs[1].name = "blinker2";  vecs[1].gens = 2;
    vecs[1].init[5] = 16'h0070;
    vecs[1].exp[5] = 16'h0070;
    vecs[2].name = "torus_blinker"; vecs[2].gens = 1;
    vecs[2].init[15] = 16'h0001; vecs[2].init[0] = 16'h0001; vecs[2].init[1] = 16'h0001;
    vecs[2].exp[0] = 16'h8003;
    vecs[3].name = "glider64";  vecs[3].gens = 64;
    vecs[3].init[1] = 16'h0002; vecs[3].init[2] = 16'h0004; vecs[3].init[3] = 16'h0007;
    vecs[3].exp[1] = 16'h0002;  vecs[3].exp[2] = 16'h0004;  vecs[3].exp[3] = 16'h0007;
    vecs[4].name = "block";     vecs[4].gens = 1;
    vecs[4].init[7] = 16'h0180; vecs[4].init[8] = 16'h0180;
    vecs[4].exp[7] = 16'h0180;  vecs[4].exp[8] = 16'h0180;
    vecs[5].name = "loners_die"; vecs[5].gens = 1;
    vecs[5].init[10] = 16'h0001; vecs[5].init[12] = 16'h0300;
    vecs[6].name = "corner_block"; vecs[6].gens = 1;
    vecs[6].init[0] = 16'h8001; vecs[6].init[15] = 16'h8001;
    vecs[6].exp[0] = 16'h8001;  vecs[6].exp[15] = 16'h8001;

    do_reset();
    check("init_allowed", 32'(bus.o_NFI_allowed), 32'd1);
    check("init_done", 32'(bus.o_done), 32'd0);
    check("init_gen", 32'(bus.o_gen_cnt), 32'd0);

    foreach (vecs[i]) begin
      do_reset();
      load_field(vecs[i].init);
      for (int g = 0; g < vecs[i].gens; g++) run_gen(vecs[i].name);
      check({vecs[i].name, "_gen"}, 32'(bus.o_gen_cnt), 32'(vecs[i].gens));
      check_field(vecs[i].name, vecs[i].exp);
    end

    // Mid-sim reset from a populated, advanced field.
    do_reset();
    check("rst_allowed", 32'(bus.o_NFI_allowed), 32'd1);
    check("rst_done", 32'(bus.o_done), 32'd0);
    check("rst_gen", 32'(bus.o_gen_cnt), 32'd0);
    exp_f = '{default: 16'h0000};
    check_field("rst", exp_f);

    // Busy window: 17 cycles of not-ready, o_done exactly when ready returns.
    begin
      int busy;
      logic done_at_ready;
      busy = 0;
      done_at_ready = 1'b0;
      exp_f = vecs[0].init;
      load_field(exp_f);
      bus.i_go = 1'b1;
      step();
      bus.i_go = 1'b0;
      for (int i = 0; i < 40 && !bus.o_NFI_allowed; i++) begin
        busy++;
        check("busy_no_done", 32'(bus.o_done), 32'd0);
        step();
      end
      done_at_ready = bus.o_done;
      check("busy_cycles", 32'(busy), 32'd17);
      check("done_at_ready", 32'(done_at_ready), 32'd1);
      step();
      check("done_one_cycle", 32'(bus.o_done), 32'd0);
    end

    // i_go held high: a generation every 18 cycles.
    begin
      int pulses, last_i;
      pulses = 0;
      last_i = -1;
      do_reset();
      bus.i_go = 1'b1;
      for (int i = 0; i < 100; i++) begin
        step();
        if (bus.o_done) begin
          pulses++;
          if (last_i >= 0) check("held_period", 32'(i - last_i), 32'd18);
          else check("held_first", 32'(i), 32'd17);
          last_i = i;
        end
      end
      check("held_pulses", 32'(pulses), 32'd5);
      check("held_gen", 32'(bus.o_gen_cnt), 32'd5);
      bus.i_go = 1'b0;
      wait_done("held_tail");
      check("held_gen_tail", 32'(bus.o_gen_cnt), 32'd6);
    end

    // Edit during CALC is dropped.
    do_reset();
    m_cur = vecs[0].init;
    load_field(m_cur);
    bus.i_go = 1'b1;
    step();
    bus.i_go = 1'b0;
    step();
    step();
    bus.i_wr_en = 1'b1; bus.i_wr_x = 4'd0; bus.i_wr_y = 4'd0; bus.i_wr_val = 1'b1;
    step();
    bus.i_wr_en = 1'b0;
    wait_done("calc_wr");
    model_life();
    check_field("calc_wr", m_cur);

    // Edit and i_go on the same edge: the third blinker cell counts.
    do_reset();
    exp_f = '{default: 16'h0000};
    exp_f[5] = 16'h0030;
    load_field(exp_f);
    bus.i_wr_en = 1'b1; bus.i_wr_x = 4'd6; bus.i_wr_y = 4'd5; bus.i_wr_val = 1'b1;
    bus.i_go = 1'b1;
    step();
    bus.i_wr_en = 1'b0;
    bus.i_go = 1'b0;
    wait_done("wr_go");
    exp_f = '{default: 16'h0000};
    exp_f[4] = 16'h0020; exp_f[5] = 16'h0020; exp_f[6] = 16'h0020;
    check_field("wr_go", exp_f);

    // Reset just before CALC computes row 7.
    do_reset();
    exp_f = vecs[3].init;
    load_field(exp_f);
    bus.i_go = 1'b1;
    step();
    bus.i_go = 1'b0;
    for (int i = 0; i < 7; i++) step();
    rst_n = 1'b0;
    #1;
    check("calc_rst_allowed", 32'(bus.o_NFI_allowed), 32'd1);
    check("calc_rst_state", 32'(dbg_state), 32'd0);
    check("calc_rst_gen", 32'(bus.o_gen_cnt), 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("calc_rst_no_done", 32'(bus.o_done), 32'd0);
    end
    exp_f = '{default: 16'h0000};
    check_field("calc_rst", exp_f);

    // Random fields against the reference model, reading a row every cycle.
    for (int f = 0; f < 4; f++) begin
      logic [15:0] exp_rd;
      do_reset();
      for (int y = 0; y < 16; y++) m_cur[y] = 16'($urandom) & 16'($urandom);
      load_field(m_cur);
      for (int g = 0; g < 50; g++) begin
        bus.i_go = 1'b1;
        bus.i_rd_row = 4'($urandom_range(0, 15));
        exp_rd = m_cur[bus.i_rd_row];
        for (int i = 0; i < 18; i++) begin
          step();
          bus.i_go = 1'b0;
          check($sformatf("rnd%0d_g%0d_rd", f, g), 32'(bus.o_rd_data), 32'(exp_rd));
          check($sformatf("rnd%0d_g%0d_done", f, g), 32'(bus.o_done), 32'(i == 17));
          check($sformatf("rnd%0d_g%0d_rdy", f, g), 32'(bus.o_NFI_allowed), 32'(i == 17));
          if (i == 17) model_life();
          bus.i_rd_row = 4'($urandom_range(0, 15));
          exp_rd = m_cur[bus.i_rd_row];
        end
      end
      check($sformatf("rnd%0d_gen", f), 32'(bus.o_gen_cnt), 32'd50);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
